// File: rtl/pdp8i_timing_gen.sv
// pdp8i_timing_gen -- PDP-8/I major-cycle timing generator.
//
// Sequences one memory cycle through the time states TS1..TS4 and emits a
// one-clock time pulse on the final clock of each state. A cycle begins on an
// accepted start and repeats back-to-back while RUN is high at the end of TS4.
// TS2 is held until core memory reports the strobe complete, or until a
// timeout expires. TS3 is stretched for as long as an IOT pause is requested.
//
// Build option:
//   PDP8I_TIMING_MEM_HANDSHAKE_EN  defined   -> TS2 waits for mem_done, with a
//                                               MEM_TIMEOUT limit; mem_err live
//                                  undefined -> TS2 is a fixed TS2_LEN clocks,
//                                               mem_done ignored, mem_err = 0
//
// Ports:
//   clk        in   system clock; all state changes on the rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   one-clock cycle request, honoured only when idle
//   run        in   RUN level, sampled on the last clock of TS4
//   mem_done   in   memory strobe complete (pulse or level)
//   io_pause   in   IOT pause, sampled once the TS3 count has expired
//   ts[3:0]    out  one-hot time state (bit0 = TS1 .. bit3 = TS4), 0 when idle
//   tp[3:0]    out  time pulse; bit n high on the final clock of TS(n+1)
//   mem_start  out  one-clock pulse on the first clock of every TS1
//   busy       out  high whenever a cycle is in progress
//   mem_err    out  sticky TS2 timeout flag, cleared by the next accepted start

module pdp8i_timing_gen #(
    parameter int unsigned TS1_LEN     = 15,
    parameter int unsigned TS2_LEN     = 15,
    parameter int unsigned TS3_LEN     = 15,
    parameter int unsigned TS4_LEN     = 15,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       run,
    input  logic       mem_done,
    input  logic       io_pause,
    output logic [3:0] ts,
    output logic [3:0] tp,
    output logic       mem_start,
    output logic       busy,
    output logic       mem_err
);

    // The state counter is reloaded with LEN-1 on entry and counts down to 0,
    // so a state lasts exactly LEN clocks when nothing stretches it.
    localparam logic [7:0] TS1_RELOAD = 8'(TS1_LEN - 1);
    localparam logic [7:0] TS2_RELOAD = 8'(TS2_LEN - 1);
    localparam logic [7:0] TS3_RELOAD = 8'(TS3_LEN - 1);
    localparam logic [7:0] TS4_RELOAD = 8'(TS4_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StS1,
        StS2,
        StS3,
        StS4
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] ts_q, ts_d;
    logic       mem_start_q, mem_start_d;
    logic [3:0] tp_c;
    logic       expired;

`ifdef PDP8I_TIMING_MEM_HANDSHAKE_EN
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              done_seen_q, done_seen_d;
    logic              mem_err_q, mem_err_d;
    logic              done_now;
`else
    // Handshake inputs and limits have no function in the fixed-length build.
    logic unused_handshake;
    assign unused_handshake = mem_done ^ (MEM_TIMEOUT == 0);
`endif

    assign expired = (cnt_q == 8'd0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_start_d = 1'b0;
        tp_c        = 4'b0000;
`ifdef PDP8I_TIMING_MEM_HANDSHAKE_EN
        // Outside TS2 the wait counter and done flag rest at 0, which also
        // gives the clear-on-entry behaviour for free.
        wait_d      = '0;
        done_seen_d = 1'b0;
        mem_err_d   = mem_err_q;
        done_now    = done_seen_q | mem_done;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StS1;
                    cnt_d       = TS1_RELOAD;
                    mem_start_d = 1'b1;
`ifdef PDP8I_TIMING_MEM_HANDSHAKE_EN
                    mem_err_d   = 1'b0;
`endif
                end
            end

            StS1: begin
                if (!expired) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    tp_c[0] = 1'b1;
                    state_d = StS2;
                    cnt_d   = TS2_RELOAD;
                end
            end

            StS2: begin
`ifdef PDP8I_TIMING_MEM_HANDSHAKE_EN
                done_seen_d = done_now;
                wait_d      = wait_q;
                if (!expired) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (done_now || (wait_q == WAIT_MAX)) begin
                    // A done on the timeout clock still counts as a good cycle.
                    tp_c[1] = 1'b1;
                    state_d = StS3;
                    cnt_d   = TS3_RELOAD;
                    if (!done_now) begin
                        mem_err_d = 1'b1;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`else
                if (!expired) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    tp_c[1] = 1'b1;
                    state_d = StS3;
                    cnt_d   = TS3_RELOAD;
                end
`endif
            end

            StS3: begin
                if (!expired) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (!io_pause) begin
                    tp_c[2] = 1'b1;
                    state_d = StS4;
                    cnt_d   = TS4_RELOAD;
                end
                // Paused: hold S3 with the count parked at 0.
            end

            StS4: begin
                if (!expired) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    tp_c[3] = 1'b1;
                    if (run) begin
                        state_d     = StS1;
                        cnt_d       = TS1_RELOAD;
                        mem_start_d = 1'b1;
                    end else begin
                        state_d = StIdle;
                        cnt_d   = 8'd0;
                    end
                end
            end

            default: begin
                state_d = StIdle;
                cnt_d   = 8'd0;
            end
        endcase

        case (state_d)
            StS1:    ts_d = 4'b0001;
            StS2:    ts_d = 4'b0010;
            StS3:    ts_d = 4'b0100;
            StS4:    ts_d = 4'b1000;
            default: ts_d = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            ts_q        <= 4'b0000;
            mem_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ts_q        <= ts_d;
            mem_start_q <= mem_start_d;
        end
    end

`ifdef PDP8I_TIMING_MEM_HANDSHAKE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q      <= '0;
            done_seen_q <= 1'b0;
            mem_err_q   <= 1'b0;
        end else begin
            wait_q      <= wait_d;
            done_seen_q <= done_seen_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;
`else
    assign mem_err = 1'b0;
`endif

    // tp depends on same-clock mem_done / io_pause, so it is decoded from the
    // registered state rather than registered itself; reset still forces it 0.
    assign tp        = tp_c;
    assign ts        = ts_q;
    assign mem_start = mem_start_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_pdp8i_timing_gen.sv
// Randomised bench for pdp8i_timing_gen against a phase/elapsed-clock model.
module tb_pdp8i_timing_gen;

    localparam int L1  = 15;
    localparam int L2  = 15;
    localparam int L3  = 15;
    localparam int L4  = 15;
    localparam int TMO = 64;
`ifdef PDP8I_TIMING_MEM_HANDSHAKE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       run;
    logic       mem_done;
    logic       io_pause;
    logic [3:0] ts;
    logic [3:0] tp;
    logic       mem_start;
    logic       busy;
    logic       mem_err;

    always #5 clk = ~clk;

    pdp8i_timing_gen #(
        .TS1_LEN    (L1),
        .TS2_LEN    (L2),
        .TS3_LEN    (L3),
        .TS4_LEN    (L4),
        .MEM_TIMEOUT(TMO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .run      (run),
        .mem_done (mem_done),
        .io_pause (io_pause),
        .ts       (ts),
        .tp       (tp),
        .mem_start(mem_start),
        .busy     (busy),
        .mem_err  (mem_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 30) begin
                $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
            end
        end
    endtask

    // Model: ph = 0 idle, 1..4 = TSn; el = clocks already spent in ph.
    int         ph;
    int         el;
    bit         seen;
    bit         err;

    // Per-segment stimulus knobs, probabilities in parts per 1000.
    int start_p [6] = '{30, 40, 40, 30, 40, 25};
    int run_init[6] = '{0, 1, 1, 0, 1, 0};
    int run_tg  [6] = '{0, 4, 3, 20, 10, 15};
    int done_p  [6] = '{40, 50, 0, 300, 60, 20};
    int pause_tg[6] = '{0, 100, 30, 250, 80, 60};

    initial begin
        int         c;
        bit         fin;
        bit         eset;
        bit         sn;
        logic [3:0] one;
        logic [3:0] exp_ts;
        logic [3:0] exp_tp;

        one      = 4'b0001;
        rst_n    = 1'b0;
        start    = 1'b0;
        run      = 1'b0;
        mem_done = 1'b0;
        io_pause = 1'b0;
        ph       = 0;
        el       = 0;
        seen     = 1'b0;
        err      = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("reset_ts", 32'(ts), 32'd0);
        check_eq("reset_tp", 32'(tp), 32'd0);
        check_eq("reset_mem_start", 32'(mem_start), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_mem_err", 32'(mem_err), 32'd0);
        rst_n = 1'b1;

        for (int seg = 0; seg < 6; seg++) begin
            run = run_init[seg][0];
            for (int n = 0; n < 1500; n++) begin
                @(negedge clk);
                start    = ($urandom_range(0, 999) < start_p[seg]);
                mem_done = ($urandom_range(0, 999) < done_p[seg]);
                if ($urandom_range(0, 999) < run_tg[seg]) run = ~run;
                if ($urandom_range(0, 999) < pause_tg[seg]) io_pause = ~io_pause;
                #2;

                c    = el + 1;
                fin  = 1'b0;
                eset = 1'b0;
                sn   = 1'b0;
                case (ph)
                    1: fin = (c == L1);
                    2: begin
                        if (HS) begin
                            sn   = seen || mem_done;
                            fin  = (c >= L2) && (sn || (c == L2 + TMO));
                            eset = fin && !sn;
                        end else begin
                            fin = (c == L2);
                        end
                    end
                    3: fin = (c >= L3) && !io_pause;
                    4: fin = (c == L4);
                    default: fin = 1'b0;
                endcase
                exp_ts = (ph == 0) ? 4'b0000 : (one << (ph - 1));
                exp_tp = fin ? exp_ts : 4'b0000;

                check_eq("ts", 32'(ts), 32'(exp_ts));
                check_eq("tp", 32'(tp), 32'(exp_tp));
                check_eq("mem_start", 32'(mem_start), 32'((ph == 1) && (c == 1)));
                check_eq("busy", 32'(busy), 32'(ph != 0));
                check_eq("mem_err", 32'(mem_err), 32'(err));

                if (seg == 4 && ph == 2 && $urandom_range(0, 9) == 0) begin
                    // Asynchronous reset mid-TS2: outputs must drop at once.
                    start = 1'b0;
                    rst_n = 1'b0;
                    #1;
                    check_eq("rst_async_ts", 32'(ts), 32'd0);
                    check_eq("rst_async_tp", 32'(tp), 32'd0);
                    check_eq("rst_async_busy", 32'(busy), 32'd0);
                    check_eq("rst_async_mem_start", 32'(mem_start), 32'd0);
                    check_eq("rst_async_mem_err", 32'(mem_err), 32'd0);
                    @(negedge clk);
                    check_eq("rst_hold_busy", 32'(busy), 32'd0);
                    rst_n = 1'b1;
                    ph    = 0;
                    el    = 0;
                    seen  = 1'b0;
                    err   = 1'b0;
                end else if (ph == 0) begin
                    if (start) begin
                        ph  = 1;
                        el  = 0;
                        err = 1'b0;
                    end
                end else if (fin) begin
                    if (eset) err = 1'b1;
                    seen = 1'b0;
                    el   = 0;
                    if (ph == 4) ph = run ? 1 : 0;
                    else ph = ph + 1;
                end else begin
                    el++;
                    if (ph == 2 && mem_done) seen = 1'b1;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
